// File: rtl/zigzag_rle_encoder_pkg.sv
// Shared types and constants for the zigzag run-length encoder: FSM states,
// the JPEG zigzag scan table and the level saturation helper.
package zigzag_pkg;

  localparam int BLOCK_COEFFS = 64;

  typedef enum logic [2:0] {IDLE, DC, SCAN, HOLD, EOB} state_t;

  // Each entry is {row[2:0], col[2:0]} of the coefficient visited at that scan position.
  localparam logic [5:0] ZZ_ORDER [BLOCK_COEFFS] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Clamp a sign-extended coefficient to the signed range of an lw-bit level.
  function automatic logic signed [63:0] sat_level(input logic signed [63:0] v, input int lw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (lw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (lw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/zigzag_rle_encoder_if.sv
// Block-in / symbol-out handshake bundle for the zigzag run-length encoder.
interface zigzag_rle_encoder_if #(
  parameter int BLOCK_SIZE    = 8,
  parameter int DCT_OUT_WIDTH = 52,
  parameter int LEVEL_WIDTH   = 16,
  parameter int RUN_WIDTH     = 6
);
  logic block_valid;
  logic block_ready;
  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][DCT_OUT_WIDTH-1:0] block;
  logic sym_valid;
  logic sym_ready;
  logic [RUN_WIDTH-1:0] sym_run;
  logic signed [LEVEL_WIDTH-1:0] sym_level;
  logic sym_dc;
  logic sym_eob;

  modport master (
    output block_valid, block, sym_ready,
    input  block_ready, sym_valid, sym_run, sym_level, sym_dc, sym_eob
  );

  modport slave (
    input  block_valid, block, sym_ready,
    output block_ready, sym_valid, sym_run, sym_level, sym_dc, sym_eob
  );
endinterface

// File: rtl/zigzag_rle_encoder_ff_en.sv
// Enabled register with asynchronous active-high reset to a parameterised value.
module ff_en #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/zigzag_rle_encoder.sv
// Scans a captured 8x8 coefficient block in zigzag order and emits
// DC, (run, level) and end-of-block symbols over a valid/ready handshake.
module zigzag_rle_encoder
  import zigzag_pkg::*;
#(
  parameter int BLOCK_SIZE    = 8,
  parameter int DCT_OUT_WIDTH = 52,
  parameter int LEVEL_WIDTH   = 16,
  parameter int RUN_WIDTH     = 6
) (
  input logic clk,
  input logic rst,
  zigzag_rle_encoder_if.slave bus
);

  state_t state, state_d;
  logic [$bits(state_t)-1:0] state_q;

  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][DCT_OUT_WIDTH-1:0] coef_buf;
  logic [5:0]               idx;
  logic [RUN_WIDTH-1:0]     run;
  logic [5:0]               zz;
  logic [DCT_OUT_WIDTH-1:0] cur;

  logic                     ready_r, valid_r, dc_r, eob_r;
  logic [RUN_WIDTH-1:0]     run_r;
  logic [LEVEL_WIDTH-1:0]   level_r;

  logic accept, fire, cur_nz, last;

  function automatic logic [LEVEL_WIDTH-1:0] to_level(input logic [DCT_OUT_WIDTH-1:0] v);
    return LEVEL_WIDTH'(sat_level(64'(signed'(v)), LEVEL_WIDTH));
  endfunction

  assign accept = bus.block_valid && ready_r;
  assign fire   = valid_r && bus.sym_ready;
  assign zz     = ZZ_ORDER[idx];
  assign cur    = coef_buf[zz[5:3]][zz[2:0]];
  assign cur_nz = (cur != '0);
  assign last   = (idx == 6'(BLOCK_COEFFS - 1));

  ff_en #(.WIDTH($bits(state_t)), .RST_VAL(IDLE)) u_state (
    .clk (clk),
    .rst (rst),
    .en  (state_d != state),
    .d   (state_d),
    .q   (state_q)
  );
  assign state = state_t'(state_q);

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = DC;
      DC:   if (fire)   state_d = SCAN;
      SCAN: begin
        if (cur_nz)    state_d = HOLD;
        else if (last) state_d = EOB;
      end
      HOLD: if (fire)   state_d = last ? EOB : SCAN;
      EOB:  if (fire)   state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Payload only; control state decides when it is meaningful, so no reset.
  always_ff @(posedge clk) begin
    if (accept) coef_buf <= bus.block;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      run_r   <= '0;
      level_r <= '0;
      dc_r    <= 1'b0;
      eob_r   <= 1'b0;
      idx     <= '0;
      run     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ready_r <= 1'b0;
          valid_r <= 1'b1;
          run_r   <= '0;
          level_r <= to_level(bus.block[0][0]);
          dc_r    <= 1'b1;
          eob_r   <= 1'b0;
        end
        DC: if (fire) begin
          valid_r <= 1'b0;
          dc_r    <= 1'b0;
          idx     <= 6'd1;
          run     <= '0;
        end
        SCAN: begin
          if (cur_nz) begin
            valid_r <= 1'b1;
            run_r   <= run;
            level_r <= to_level(cur);
          end else begin
            run <= run + RUN_WIDTH'(1);
            if (last) begin
              valid_r <= 1'b1;
              run_r   <= '0;
              level_r <= '0;
              eob_r   <= 1'b1;
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        HOLD: if (fire) begin
          run <= '0;
          // The last coefficient being nonzero still leads to an explicit EOB.
          if (last) begin
            run_r   <= '0;
            level_r <= '0;
            eob_r   <= 1'b1;
          end else begin
            valid_r <= 1'b0;
            idx     <= idx + 6'd1;
          end
        end
        EOB: if (fire) begin
          valid_r <= 1'b0;
          eob_r   <= 1'b0;
          ready_r <= 1'b1;
          idx     <= '0;
          run     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.block_ready = ready_r;
  assign bus.sym_valid   = valid_r;
  assign bus.sym_run     = run_r;
  assign bus.sym_level   = level_r;
  assign bus.sym_dc      = dc_r;
  assign bus.sym_eob     = eob_r;

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Randomised and directed bench for zigzag_rle_encoder against a diagonal-walk
// reference model of zigzag scanning and run-length symbol generation.
module tb_zigzag_rle_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  zigzag_rle_encoder_if #(.BLOCK_SIZE(8), .DCT_OUT_WIDTH(52), .LEVEL_WIDTH(16), .RUN_WIDTH(6)) bus ();

  zigzag_rle_encoder #(.BLOCK_SIZE(8), .DCT_OUT_WIDTH(52), .LEVEL_WIDTH(16), .RUN_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic              dc;
    logic              eob;
    logic [5:0]        run;
    logic signed [15:0] level;
  } sym_t;

  longint coef [8][8];
  int     zz_r [64];
  int     zz_c [64];
  sym_t   exp_q [$];
  sym_t   got_q [$];
  int     checks   = 0;
  int     failures = 0;

  // Zigzag order as alternating anti-diagonal walks.
  function automatic void build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      for (int k = 0; k < 8; k++) begin
        int r = (s % 2 == 1) ? k : 7 - k;
        int c = s - r;
        if (c >= 0 && c < 8) begin
          zz_r[n] = r;
          zz_c[n] = c;
          n++;
        end
      end
    end
  endfunction

  function automatic sym_t mk(logic dc, logic eob, int run, longint v);
    sym_t s;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    s.dc = dc; s.eob = eob; s.run = 6'(run); s.level = 16'(v);
    return s;
  endfunction

  function automatic void build_expected();
    int run = 0;
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 1'b0, 0, coef[0][0]));
    for (int k = 1; k < 64; k++) begin
      if (coef[zz_r[k]][zz_c[k]] == 0) run++;
      else begin
        exp_q.push_back(mk(1'b0, 1'b0, run, coef[zz_r[k]][zz_c[k]]));
        run = 0;
      end
    end
    exp_q.push_back(mk(1'b0, 1'b1, 0, 0));
  endfunction

  function automatic sym_t observed();
    sym_t s;
    s.dc = bus.sym_dc; s.eob = bus.sym_eob; s.run = bus.sym_run; s.level = bus.sym_level;
    return s;
  endfunction

  task automatic clear_coef();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) coef[r][c] = 0;
  endtask

  task automatic load_block();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) bus.block[r][c] = coef[r][c][51:0];
  endtask

  task automatic random_coef();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
      int p = int'($urandom_range(99));
      longint v = 0;
      if (p >= 90) begin
        v = longint'({$urandom(), $urandom()});
        v = (v <<< 12) >>> 12;
      end else if (p >= 60) begin
        v = longint'($urandom_range(600)) - 300;
      end
      coef[r][c] = v;
    end
  endtask

  // Runs one block from the current negedge; returns at the negedge where the
  // EOB is being accepted. Stalls each symbol 'stall' cycles before accepting.
  task automatic run_block(input string name, input int stall, input int pulse_at,
                           output int lat, output int wait_cnt);
    int t, st;
    bit done;
    sym_t prev, s;
    build_expected();
    load_block();
    got_q.delete();
    lat = -1;
    wait_cnt = 0;
    while (bus.block_ready !== 1'b1 && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (bus.block_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s block_ready_timeout got=%b want=1", name, bus.block_ready);
      return;
    end
    bus.block_valid = 1'b1;
    @(negedge clk);
    bus.block_valid = 1'b0;
    t = 0; st = 0; done = 1'b0;
    while (!done && t < 3000) begin
      if (bus.sym_valid === 1'b1) begin
        s = observed();
        if (bus.sym_eob === 1'b1 && lat < 0) lat = t;
        if (st == 0) prev = s;
        else begin
          checks++;
          if (s !== prev) begin
            failures++;
            $display("FAIL %s stable got=%p want=%p", name, s, prev);
          end
        end
        if (st < stall) begin
          bus.sym_ready = 1'b0;
          st++;
        end else begin
          got_q.push_back(s);
          bus.sym_ready = 1'b1;
          st = 0;
          if (s.eob) done = 1'b1;
        end
      end else begin
        bus.sym_ready = (stall == 0);
      end
      checks++;
      if (bus.block_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s busy_ready t=%0d got=%b want=0", name, t, bus.block_ready);
      end
      bus.block_valid = (t == pulse_at);
      if (!done) begin
        @(negedge clk);
        t++;
      end
    end
    bus.block_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s eob_timeout got=%0d symbols", name, got_q.size());
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s count got=%0d want=%0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s sym%0d got dc=%0d eob=%0d run=%0d level=%0d want dc=%0d eob=%0d run=%0d level=%0d",
                 name, i, got_q[i].dc, got_q[i].eob, got_q[i].run, got_q[i].level,
                 exp_q[i].dc, exp_q[i].eob, exp_q[i].run, exp_q[i].level);
      end
    end
  endtask

  task automatic test_reset();
    bus.block_valid = 1'b0;
    bus.sym_ready   = 1'b0;
    bus.block       = '0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (bus.sym_valid !== 1'b0)   begin failures++; $display("FAIL reset_sym_valid got=%b want=0", bus.sym_valid); end
    if (bus.block_ready !== 1'b1) begin failures++; $display("FAIL reset_block_ready got=%b want=1", bus.block_ready); end
    if (bus.sym_run !== 6'd0)     begin failures++; $display("FAIL reset_sym_run got=%0d want=0", bus.sym_run); end
    if (bus.sym_level !== 16'sd0) begin failures++; $display("FAIL reset_sym_level got=%0d want=0", bus.sym_level); end
    if (bus.sym_dc !== 1'b0)      begin failures++; $display("FAIL reset_sym_dc got=%b want=0", bus.sym_dc); end
    if (bus.sym_eob !== 1'b0)     begin failures++; $display("FAIL reset_sym_eob got=%b want=0", bus.sym_eob); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dc_only();
    int lat, w;
    clear_coef();
    coef[0][0] = 5;
    run_block("dc_only", 0, -1, lat, w);
    @(negedge clk);
    checks++;
    if (bus.block_ready !== 1'b1) begin
      failures++;
      $display("FAIL dc_only_ready_after_eob got=%b want=1", bus.block_ready);
    end
  endtask

  task automatic scenario2();
    clear_coef();
    coef[0][0] = -3;
    coef[0][1] = 7;
    coef[2][0] = -2;
  endtask

  task automatic test_two_ac();
    int lat, w;
    scenario2();
    run_block("two_ac", 0, -1, lat, w);
  endtask

  task automatic test_corner_77();
    int lat, w;
    clear_coef();
    coef[7][7] = 1;
    run_block("corner_77", 0, -1, lat, w);
    checks++;
    if (lat != 65) begin
      failures++;
      $display("FAIL corner_77_latency got=%0d want=65", lat);
    end
  endtask

  task automatic test_saturation();
    int lat, w;
    clear_coef();
    coef[0][0] = 40000;
    coef[0][1] = -1;
    run_block("sat_pos", 0, -1, lat, w);
    clear_coef();
    coef[0][0] = -40000;
    coef[3][4] = 64'sd1 <<< 50;
    run_block("sat_neg", 0, -1, lat, w);
  endtask

  task automatic test_backpressure();
    int lat, w;
    scenario2();
    run_block("backpressure", 5, 12, lat, w);
  endtask

  task automatic test_mid_reset();
    int t, lat, w;
    sym_t s;
    scenario2();
    load_block();
    t = 0;
    while (bus.block_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    bus.block_valid = 1'b1;
    @(negedge clk);
    bus.block_valid = 1'b0;
    bus.sym_ready   = 1'b1;
    t = 0;
    while (t < 100 && !(bus.sym_valid === 1'b1 && bus.sym_dc === 1'b0 && bus.sym_eob === 1'b0)) begin
      @(negedge clk);
      t++;
    end
    bus.sym_ready = 1'b0;
    s = observed();
    checks++;
    if (t >= 100 || s !== mk(1'b0, 1'b0, 0, 7)) begin
      failures++;
      $display("FAIL mid_reset_hold_sym got=%p want run=0 level=7 (t=%0d)", s, t);
    end
    #1 rst = 1'b1;
    #1;
    checks += 2;
    if (bus.sym_valid !== 1'b0)   begin failures++; $display("FAIL mid_reset_sym_valid got=%b want=0", bus.sym_valid); end
    if (bus.block_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_block_ready got=%b want=1", bus.block_ready); end
    @(negedge clk);
    rst = 1'b0;
    clear_coef();
    coef[0][0] = 5;
    run_block("after_reset", 0, -1, lat, w);
  endtask

  task automatic test_random();
    int lat, w;
    for (int n = 0; n < 12; n++) begin
      random_coef();
      run_block($sformatf("random%0d", n), int'($urandom_range(2)), -1, lat, w);
    end
  endtask

  task automatic test_back_to_back();
    int lat, w;
    for (int n = 0; n < 3; n++) begin
      random_coef();
      run_block($sformatf("b2b%0d", n), 0, -1, lat, w);
      if (n > 0) begin
        checks++;
        if (w != 1) begin
          failures++;
          $display("FAIL b2b%0d_ready_gap got=%0d want=1", n, w);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    build_zz();
    test_reset();
    test_dc_only();
    test_two_ac();
    test_corner_77();
    test_saturation();
    test_backpressure();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zigzag_rle_encoder.md
Name: zigzag_rle_encoder

Overview:
Downstream stage of the block compressor. Accepts one 8x8 block of quantized DCT coefficients and scans it in JPEG zigzag order. It emits a stream of (run, level) symbols over a valid/ready handshake: a DC symbol first, then one symbol per nonzero AC coefficient, then an end-of-block (EOB) symbol. Its output feeds the entropy coder.

Parameters:
BLOCK_SIZE, 8, block edge; fixed at 8 because the zigzag table is 64 entries.
DCT_OUT_WIDTH, 52, width of each signed input coefficient; matches the compressor output.
LEVEL_WIDTH, 16, width of the signed output level field.
RUN_WIDTH, 6, width of the zero-run field; must hold 62.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
block_valid  in  1  input block is present
block  in  DCT_OUT_WIDTH x [BLOCK_SIZE][BLOCK_SIZE]  signed coefficients, indexed [row][col]
block_ready  out  1  encoder can accept a block
sym_valid  out  1  output symbol is valid
sym_ready  in  1  consumer accepts the symbol
sym_run  out  RUN_WIDTH  number of zeros preceding the level
sym_level  out  LEVEL_WIDTH  signed, saturated coefficient value
sym_dc  out  1  symbol is the DC term
sym_eob  out  1  symbol is end-of-block

Behaviour:
- Reset (async, active-high):
  - state=IDLE, block_ready=1.
  - sym_valid=0; sym_run, sym_level, sym_dc, sym_eob = 0.
  - Index and run counters = 0; the coefficient buffer is not reset.
- States: IDLE, DC, SCAN, HOLD, EOB.
- IDLE:
  - block_ready=1.
  - On block_valid&&block_ready at edge N: capture all 64 coefficients into the internal buffer. Go to DC.
  - DC symbol is valid from cycle N+1.
- DC: output reg = {run=0, level=sat(coef[0][0]), dc=1, eob=0}; sym_valid=1.
  - The DC symbol is emitted even when DC is 0.
  - On handshake: idx=1, run=0, go to SCAN.
- SCAN: each cycle examine buffer[ZZ_ORDER[idx]].
  - Zero: run++. If idx==63, go to EOB; else idx++.
  - Nonzero: load output reg {run, sat(level), dc=0, eob=0}, sym_valid=1, go to HOLD.
- HOLD: on handshake, run=0.
  - If idx==63, go to EOB; else idx++ and return to SCAN.
- EOB: output reg = {run=0, level=0, dc=0, eob=1}, sym_valid=1.
  - EOB is always emitted, including when coefficient 63 is nonzero.
  - On handshake, go to IDLE; block_ready rises the next cycle.
- Handshake rules:
  - Outputs are driven from registers.
  - While sym_valid=1 and sym_ready=0, all sym_* fields hold stable.
  - block_ready=1 only in IDLE. block_valid is ignored in other states.
- Throughput: one coefficient examined per cycle. A zero costs 1 cycle; a nonzero costs at least 2 cycles (SCAN + HOLD).
- Saturation: sat() clamps a DCT_OUT_WIDTH signed value to [-2^(LEVEL_WIDTH-1), 2^(LEVEL_WIDTH-1)-1].
- Run width: max run is 62 (coef[7][7] alone after DC), so no zero-run-length escape code is needed.
- Mid-operation reset: all outputs go to their reset values immediately, the partial block is dropped, and the encoder restarts in IDLE.

Decomposition:
- Package zigzag_pkg holds:
  - state enum;
  - ZZ_ORDER constant (64 entries of {row, col}, standard JPEG order);
  - the sat_level function;
  - BLOCK_COEFFS=64.
- The state register uses the existing ff_en flop.
- No further sub-module is required; the scan datapath stays in one module.

Test Plan:
1. Block with DC=5, all AC=0 -> exactly 2 symbols: {dc=1, run=0, level=5}, then {eob=1}. block_ready returns 1 one cycle after the EOB handshake.
2. DC=-3, coef[0][1]=7 (zz 1), coef[2][0]=-2 (zz 3), rest 0 -> {dc,0,-3}, {0,7}, {1,-2}, {eob}.
3. Only coef[7][7]=1 -> {dc,0,0}, {run=62, level=1}, {eob}. Minimum latency is 65 cycles from accept to EOB with sym_ready held high.
4. DC=40000 -> level=32767. In a second block, DC=-40000 -> level=-32768. coef[0][1]=-1 -> level=-1, not saturated.
5. Repeat scenario 2 with sym_ready low for 5 cycles on each symbol:
   - the fields stay stable and no symbol is lost or duplicated;
   - block_ready stays 0 throughout;
   - a block_valid pulse issued mid-block is ignored.
6. Assert rst for 1 cycle during HOLD of scenario 2 -> sym_valid=0 asynchronously and block_ready=1. A following scenario-1 block produces exactly its 2 symbols.
